// File: rtl/musa_pkg.sv
// Shared MUSA core constants: datapath/stack defaults, pcSrc encoding and stack op codes.
package musa_pkg;

  localparam int MUSA_DATA_WIDTH  = 32;
  localparam int MUSA_STACK_DEPTH = 8;

  // pcSrc encoding shared by the decoder and the PC-select mux
  localparam logic [2:0] PCSRC_RET    = 3'b000;
  localparam logic [2:0] PCSRC_NEXT   = 3'b001;
  localparam logic [2:0] PCSRC_BRANCH = 3'b010;
  localparam logic [2:0] PCSRC_JUMP   = 3'b011;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_REPLACE
  } stack_op_t;

endpackage

// File: rtl/rise_detect.sv
// Strobe rising-edge detector; register loads from the strobe even in reset so a held strobe never fires.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic fire
);

  logic strobe_q;

  always_ff @(posedge clk) begin
    strobe_q <= strobe;
  end

  // reset masks the edge so an operation coinciding with reset is dropped
  assign fire = strobe & ~strobe_q & ~reset;

endmodule

// File: rtl/call_stack.sv
// Return-address LIFO for CALL/RET, one operation per aux_push_pop rising edge, 1-cycle update latency.
// CALL_STACK_ERR_EN: drop push-when-full and raise sticky overflow/underflow; otherwise ring overwrite.
module call_stack
  import musa_pkg::*;
#(
  parameter int DATA_WIDTH = MUSA_DATA_WIDTH,
  parameter int DEPTH      = MUSA_STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   aux_push_pop,
  input  logic [DATA_WIDTH-1:0]  push_data,
  output logic [DATA_WIDTH-1:0]  top_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                  fire;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         ptr_m1;
  logic [AW-1:0]         ptr_m2;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] top_q;
  logic                  is_empty;
  logic                  is_full;
  logic                  push_ok;
  logic                  mem_we;
  logic [AW-1:0]         mem_wa;
  stack_op_t             op;

  rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .strobe (aux_push_pop),
    .fire   (fire)
  );

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign ptr_m1   = wr_ptr - AW'(1);
  assign ptr_m2   = wr_ptr - AW'(2);

`ifdef CALL_STACK_ERR_EN
  assign push_ok = ~is_full;
`else
  assign push_ok = 1'b1;
`endif

  always_comb begin
    op = STK_NOP;
    if (fire) begin
      if (push && (!pop || is_empty)) op = STK_PUSH;
      else if (push && pop)           op = STK_REPLACE;
      else if (pop)                   op = STK_POP;
    end
  end

  assign mem_we = ((op == STK_PUSH) && push_ok) || (op == STK_REPLACE);
  assign mem_wa = (op == STK_REPLACE) ? ptr_m1 : wr_ptr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= push_data;
  end

`ifdef CALL_STACK_ERR_EN
  logic ovf_q;
  logic unf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      cnt_q  <= '0;
      top_q  <= '0;
`ifdef CALL_STACK_ERR_EN
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
`endif
    end else begin
      case (op)
        STK_PUSH: begin
          if (push_ok) begin
            // when full (ring mode) the pointer keeps walking and overwrites the oldest slot
            wr_ptr <= wr_ptr + AW'(1);
            top_q  <= push_data;
            if (!is_full) cnt_q <= cnt_q + CW'(1);
          end
`ifdef CALL_STACK_ERR_EN
          else begin
            ovf_q <= 1'b1;
          end
`endif
        end
        STK_REPLACE: top_q <= push_data;
        STK_POP: begin
          if (cnt_q > CW'(1)) begin
            wr_ptr <= ptr_m1;
            cnt_q  <= cnt_q - CW'(1);
            top_q  <= mem[ptr_m2];
          end else if (cnt_q == CW'(1)) begin
            wr_ptr <= ptr_m1;
            cnt_q  <= '0;
            top_q  <= '0;
          end
`ifdef CALL_STACK_ERR_EN
          else begin
            unf_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign top_data = top_q;
  assign count    = cnt_q;
  assign empty    = is_empty;
  assign full     = is_full;

`ifdef CALL_STACK_ERR_EN
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: stimulus queues expected state, a negedge monitor pops and compares.
module tb_call_stack;

`ifdef CALL_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic        aux_push_pop;
  logic [31:0] push_data;
  logic [31:0] top_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    int          cnt;
    logic [31:0] top;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t sb[$];

  call_stack #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .aux_push_pop (aux_push_pop),
    .push_data    (push_data),
    .top_data     (top_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // monitor: outputs are sampled on the falling edge, away from the update edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (count !== 4'(e.cnt) || top_data !== e.top || empty !== (e.cnt == 0) ||
            full !== (e.cnt == 8) || overflow !== e.ovf || underflow !== e.unf) begin
          miscompares++;
          $display("FAIL %s: got count=%0d top=%h empty=%b full=%b ovf=%b unf=%b, want count=%0d top=%h empty=%b full=%b ovf=%b unf=%b",
                   e.name, count, top_data, empty, full, overflow, underflow,
                   e.cnt, e.top, (e.cnt == 0), (e.cnt == 8), e.ovf, e.unf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  // queue one expectation; it is checked at the next falling edge
  task automatic expect_state(input string nm, input int c, input logic [31:0] t,
                              input bit o, input bit u);
    exp_t e;
    e.name = nm; e.cnt = c; e.top = t; e.ovf = o; e.unf = u;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // one low cycle, then one strobe pulse with the given request
  task automatic fire_op(input bit p, input bit q, input logic [31:0] d, input string nm,
                         input int c, input logic [31:0] t, input bit o, input bit u);
    @(posedge clk); #1;
    aux_push_pop = 1'b1; push = p; pop = q; push_data = d;
    @(posedge clk); #1;
    aux_push_pop = 1'b0; push = 1'b0; pop = 1'b0;
    expect_state(nm, c, t, o, u);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; aux_push_pop = 1'b1; push = 1'b1; pop = 1'b0; push_data = 32'h0000_00AA;

    // reset with strobe high, then strobe held high after release
    @(posedge clk); #1;
    expect_state("rst_cyc1", 0, 32'h0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) expect_state("rst_strobe_held", 0, 32'h0, 0, 0);
    aux_push_pop = 1'b0; push = 1'b0;
    expect_state("rst_strobe_low", 0, 32'h0, 0, 0);

    // two calls, two returns
    fire_op(1, 0, 32'h10, "push_10", 1, 32'h10, 0, 0);
    fire_op(1, 0, 32'h20, "push_20", 2, 32'h20, 0, 0);
    fire_op(0, 1, 32'h0,  "pop_1",   1, 32'h10, 0, 0);
    fire_op(0, 1, 32'h0,  "pop_2",   0, 32'h0,  0, 0);

    // push and pop together replaces the top
    fire_op(1, 0, 32'h10, "rp_push_10", 1, 32'h10, 0, 0);
    fire_op(1, 0, 32'h20, "rp_push_20", 2, 32'h20, 0, 0);
    fire_op(1, 1, 32'h30, "replace_30", 2, 32'h30, 0, 0);
    fire_op(0, 1, 32'h0,  "rp_pop_1",   1, 32'h10, 0, 0);
    fire_op(0, 1, 32'h0,  "rp_pop_2",   0, 32'h0,  0, 0);
    fire_op(1, 1, 32'h3C, "pushpop_empty", 1, 32'h3C, 0, 0);
    fire_op(0, 1, 32'h0,  "pushpop_empty_pop", 0, 32'h0, 0, 0);

    // pop on empty; underflow is sticky when enabled
    fire_op(0, 1, 32'h0,  "pop_empty",        0, 32'h0,  0, ERR);
    expect_state("pop_empty_idle",            0, 32'h0,  0, ERR);
    fire_op(1, 0, 32'h66, "unf_sticky_push",  1, 32'h66, 0, ERR);
    fire_op(0, 1, 32'h0,  "unf_sticky_pop",   0, 32'h0,  0, ERR);
    do_reset();
    expect_state("unf_cleared", 0, 32'h0, 0, 0);

    // overflow: push 1..9 into an 8-deep stack
    for (int i = 1; i <= 8; i++) fire_op(1, 0, 32'(i), "ovf_fill", i, 32'(i), 0, 0);
    fire_op(1, 0, 32'd9, "ovf_push9", 8, ERR ? 32'd8 : 32'd9, ERR, 0);
    for (int k = 1; k <= 8; k++)
      fire_op(0, 1, 32'h0, "ovf_drain", 8 - k,
              (k == 8) ? 32'd0 : (ERR ? 32'(8 - k) : 32'(9 - k)), ERR, 0);
    fire_op(0, 1, 32'h0, "ovf_drain_extra", 0, 32'h0, ERR, ERR);
    do_reset();
    expect_state("ovf_cleared", 0, 32'h0, 0, 0);

    // long strobe: one push only; the read during the fire cycle sees the old top
    @(posedge clk); #1;
    aux_push_pop = 1'b1; push = 1'b1; push_data = 32'h55;
    expect_state("long_pre", 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) expect_state("long_held", 1, 32'h55, 0, 0);
    aux_push_pop = 1'b0; push = 1'b0;
    expect_state("long_release", 1, 32'h55, 0, 0);

    // reset coinciding with a fire drops the operation
    fire_op(1, 0, 32'h44, "prec_push", 2, 32'h44, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1; aux_push_pop = 1'b1; push = 1'b1; push_data = 32'h77;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_state("prec_after", 0, 32'h0, 0, 0);
    aux_push_pop = 1'b0; push = 1'b0;
    expect_state("prec_idle", 0, 32'h0, 0, 0);

    repeat (2) @(posedge clk);
    #1;

    // final direct checks of the settled idle state
    if (count !== 4'd0) begin
      miscompares++;
      $display("FAIL final_count: got count=%0d, want 0", count);
    end
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL final_flags: got empty=%b full=%b, want empty=1 full=0", empty, full);
    end
    if (top_data !== 32'h0) begin
      miscompares++;
      $display("FAIL final_top: got top=%h, want 0", top_data);
    end
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL final_err: got ovf=%b unf=%b, want 0 0", overflow, underflow);
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expectations left unchecked, want 0", sb.size());
    end
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL coverage: only %0d vectors checked, want at least 12", vectors);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else                  $display("FAIL: %0d miscompares", miscompares);
    $finish;
  end

endmodule
